lvdc_din_loader: RTL

Serial load sequencer for the LVDC serial data input. Accepts 26-bit words from a host-side requester over a valid/ready handshake. Holds the computer halted via HALTV, shifts each word MSB-first onto DIN framed by DATAV, and flags each completed word with a one-cycle INTCV pulse. Releases the halt on request once the final word of a load has been delivered. Sits between the ground-support/test harness logic and the `lvdc` core's HALTV/DATAV/DIN/INTCV inputs.

---
 rtl/lvdc_din_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lvdc_din_loader.sv
// rtl/lvdc_din_loader.sv - serial load sequencer driving LVDC HALTV/DATAV/DIN/INTCV
//
// Accepts WORD_W-bit words over a valid/ready handshake, holds the computer
// halted, shifts each word MSB-first onto DIN framed by DATAV and pulses
// INTCV once per completed word. Halt is released after the final word.
//
// Optional feature macro: LVDC_LOADER_PARITY_EN appends one odd-parity bit
// (XNOR-reduce of the word) after the data bits.
//
// Ports:
//   CLK        system clock, rising edge
//   CSTN       asynchronous active-low reset
//   run_req    level, request run (HALTV=0) when no load is active
//   word_valid / word_data / word_last / word_ready   word handshake
//   load_busy  load in progress, first accept through DONE
//   HALTV      halt to LVDC, 1 = halted
//   DATAV      data-valid frame to LVDC
//   DIN        serial data to LVDC
//   INTCV      one-cycle word-complete interrupt
module lvdc_din_loader #(
    parameter int WORD_W     = 26,
    parameter int BIT_DIV    = 4,
    parameter int GAP_CYC    = 2,
    parameter int HALT_SETUP = 8
) (
    input  logic              CLK,
    input  logic              CSTN,
    input  logic              run_req,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              load_busy,
    output logic              HALTV,
    output logic              DATAV,
    output logic              DIN,
    output logic              INTCV
);

`ifdef LVDC_LOADER_PARITY_EN
    localparam int NB = WORD_W + 1;
`else
    localparam int NB = WORD_W;
`endif
    localparam int BW = $clog2(NB + 1);
    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, HSETUP, SHIFT, GAP, DONE} state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   shreg_q, shreg_d;
    logic            last_q, last_d;
    logic            active_q, active_d;
    logic [CW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            haltv_q, haltv_d;
    logic            datav_q, datav_d;
    logic            din_q, din_d;
    logic            intcv_q, intcv_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        last_d   = last_q;
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        haltv_d  = haltv_q;
        datav_d  = datav_q;
        din_d    = din_q;
        intcv_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // ready_q gates IDLE behaviour so the first cycle after
                // reset only raises word_ready and leaves HALTV high.
                if (ready_q && word_valid) begin
`ifdef LVDC_LOADER_PARITY_EN
                    shreg_d = {word_data, ~^word_data};
`else
                    shreg_d = word_data;
`endif
                    last_d   = word_last;
                    active_d = 1'b1;
                    div_d    = '0;
                    bit_d    = '0;
                    cnt_d    = '0;
                    if (haltv_q) begin
                        state_d = SHIFT;
                        datav_d = 1'b1;
                        din_d   = word_data[WORD_W-1];
                    end else begin
                        haltv_d = 1'b1;
                        state_d = HSETUP;
                    end
                end else if (ready_q) begin
                    haltv_d = active_q | ~run_req;
                end
            end
            HSETUP: begin
                if (cnt_q == CW'(HALT_SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                    datav_d = 1'b1;
                    din_d   = shreg_q[NB-1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q == CW'(BIT_DIV - 1)) begin
                    div_d = '0;
                    if (bit_q == BW'(NB - 1)) begin
                        state_d = GAP;
                        datav_d = 1'b0;
                        din_d   = 1'b0;
                        intcv_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                        din_d   = shreg_q[NB-2];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = last_q ? DONE : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = active_d;
    end

    always_ff @(posedge CLK or negedge CSTN) begin
        if (!CSTN) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            last_q   <= 1'b0;
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            haltv_q  <= 1'b1;
            datav_q  <= 1'b0;
            din_q    <= 1'b0;
            intcv_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            haltv_q  <= haltv_d;
            datav_q  <= datav_d;
            din_q    <= din_d;
            intcv_q  <= intcv_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign word_ready = ready_q;
    assign load_busy  = busy_q;
    assign HALTV      = haltv_q;
    assign DATAV      = datav_q;
    assign DIN        = din_q;
    assign INTCV      = intcv_q;

endmodule
